// File: rtl/figo_route_logger_if.sv
// Readout bus of the route logger: show-ahead FIFO head with valid/ready.
// master = the logger (drives head), slave = the telemetry consumer.
interface figo_route_logger_if #(
  parameter int LOC_W = 3
);
  logic             rd_valid;
  logic             rd_ready;
  logic [LOC_W-1:0] rd_data;

  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/figo_route_logger.sv
// Route logger for the FIGO rover: logs every location change into a
// show-ahead FIFO, counts moves, flags arrival at a target and flags stalls.
module figo_route_logger #(
  parameter int LOC_W        = 3,
  parameter int DEPTH        = 8,
  parameter int STALL_CYCLES = 16,
  parameter int CNT_W        = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LOC_W-1:0]         current_location,
  input  logic [LOC_W-1:0]         target_location,
  input  logic                     log_enable,
  figo_route_logger_if.master      rd_if,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         move_count,
  output logic                     arrived,
  output logic                     overflow,
  output logic                     stalled
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STALL_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_ARRIVED} state_t;

  state_t           r_state, w_state_nxt;
  logic [LOC_W-1:0] r_prev;
  logic [SW-1:0]    r_stall, w_stall_nxt;
  logic [CNT_W-1:0] r_move;
  logic             r_arrived, r_overflow;
  logic             w_push, w_move, w_hit;

  logic [LOC_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_pop, w_full, w_wr, w_empty;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state, push/move decisions and next stall count. The stall count
  // defaults to 0 so it clears on a change, on leaving TRACK and outside TRACK.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_move      = 1'b0;
    w_hit       = 1'b0;
    w_stall_nxt = '0;
    case (r_state)
      S_IDLE: begin
        // Start entry: logged but not counted as a move.
        if (log_enable) begin
          w_push      = 1'b1;
          w_state_nxt = S_TRACK;
        end
      end
      S_TRACK: begin
        if (!log_enable) begin
          w_state_nxt = S_IDLE;
        end else if (current_location != r_prev) begin
          w_push = 1'b1;
          w_move = 1'b1;
        end else if (r_stall != SW'(STALL_CYCLES)) begin
          w_stall_nxt = r_stall + SW'(1);
        end else begin
          w_stall_nxt = r_stall;
        end
      end
      default: begin
        if (!log_enable) w_state_nxt = S_IDLE;
      end
    endcase
    // Arrival is judged on whatever value is being logged this edge.
    if (w_push && (current_location == target_location)) begin
      w_hit       = 1'b1;
      w_state_nxt = S_ARRIVED;
    end
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_pop   = !w_empty && rd_if.rd_ready;
  // A push into a full FIFO still lands if the head leaves on the same edge.
  assign w_wr    = w_push && (!w_full || w_pop);

  // Tracking registers: last logged location, stall count, moves, flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev     <= '0;
      r_stall    <= '0;
      r_move     <= '0;
      r_arrived  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_prev <= current_location;
      r_stall   <= w_stall_nxt;
      if (w_move && (r_move != {CNT_W{1'b1}})) r_move <= r_move + CNT_W'(1);
      r_arrived <= w_hit;
      if (w_push && !w_wr) r_overflow <= 1'b1;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= current_location;
  end

  // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^AW).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_if.rd_valid = !w_empty;
  assign rd_if.rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign fifo_count     = r_count;
  assign move_count     = r_move;
  assign arrived        = r_arrived;
  assign overflow       = r_overflow;
  assign stalled        = (r_state == S_TRACK) && (r_stall == SW'(STALL_CYCLES));
endmodule

// File: tb/tb_figo_route_logger.sv
// Bench for figo_route_logger: directed plan steps then random traffic,
// every cycle compared against a queue-based behavioural model.
module tb_figo_route_logger;
  localparam int LOC_W = 3;
  localparam int DEPTH = 8;
  localparam int STALL = 16;

  logic             clk = 1'b0;
  logic             reset, log_enable;
  logic [LOC_W-1:0] current_location, target_location;
  logic [3:0]       fifo_count, fifo_count2;
  logic [7:0]       move_count;
  logic [1:0]       move_count2;
  logic             arrived, overflow, stalled;
  logic             arrived2, overflow2, stalled2;

  int checks = 0;
  int errors = 0;

  figo_route_logger_if #(.LOC_W(LOC_W)) rd_if  ();
  figo_route_logger_if #(.LOC_W(LOC_W)) rd_if2 ();
  assign rd_if2.rd_ready = rd_if.rd_ready;

  figo_route_logger #(.LOC_W(LOC_W), .DEPTH(DEPTH), .STALL_CYCLES(STALL), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .current_location(current_location),
    .target_location(target_location), .log_enable(log_enable), .rd_if(rd_if),
    .fifo_count(fifo_count), .move_count(move_count), .arrived(arrived),
    .overflow(overflow), .stalled(stalled));

  // Narrow move counter copy: only its saturation is checked.
  figo_route_logger #(.LOC_W(LOC_W), .DEPTH(DEPTH), .STALL_CYCLES(STALL), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .current_location(current_location),
    .target_location(target_location), .log_enable(log_enable), .rd_if(rd_if2),
    .fifo_count(fifo_count2), .move_count(move_count2), .arrived(arrived2),
    .overflow(overflow2), .stalled(stalled2));

  always #5 clk = ~clk;

  // Behavioural model: visited-location queue plus a few scalars.
  int q[$];
  int m_prev, m_moves, m_stall, m_mode; // mode: 0 idle, 1 logging, 2 arrived
  bit m_ovf, m_arr;

  task automatic model_step();
    bit push, pop;
    int v;
    push = 0; v = 0;
    if (reset) begin
      q.delete(); m_prev = 0; m_moves = 0; m_ovf = 0; m_stall = 0; m_mode = 0; m_arr = 0;
      return;
    end
    pop = (q.size() != 0) && rd_if.rd_ready;
    m_arr = 0;
    case (m_mode)
      0: if (log_enable) begin push = 1; v = current_location; m_prev = v; m_mode = 1; end
      1: if (!log_enable) begin m_mode = 0; m_stall = 0; end
         else if (int'(current_location) != m_prev) begin
           push = 1; v = current_location; m_prev = v; m_moves++; m_stall = 0;
         end else if (m_stall < STALL) m_stall++;
      default: if (!log_enable) m_mode = 0;
    endcase
    if (push && v == int'(target_location)) begin m_mode = 2; m_arr = 1; m_stall = 0; end
    if (pop) void'(q.pop_front());
    if (push) begin
      if (q.size() < DEPTH) q.push_back(v);
      else m_ovf = 1;
    end
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("rd_valid",   rd_if.rd_valid, (q.size() != 0) ? 1 : 0);
    chk("rd_data",    rd_if.rd_data,  (q.size() != 0) ? q[0] : 0);
    chk("fifo_count", fifo_count,     q.size());
    chk("move_count", move_count,     (m_moves > 255) ? 255 : m_moves);
    chk("move_sat2",  move_count2,    (m_moves > 3) ? 3 : m_moves);
    chk("arrived",    arrived,        m_arr);
    chk("overflow",   overflow,       m_ovf);
    chk("stalled",    stalled,        (m_mode == 1 && m_stall == STALL) ? 1 : 0);
  endtask

  // One clock: drive inputs, advance model, sample 1 time unit after the edge.
  task automatic cyc(input bit rs, input bit le, input int loc, input int tgt, input bit rr);
    reset = rs; log_enable = le; current_location = LOC_W'(loc);
    target_location = LOC_W'(tgt); rd_if.rd_ready = rr;
    model_step();
    @(posedge clk); #1;
    check_all();
  endtask

  initial begin
    reset = 1; log_enable = 0; current_location = 0; target_location = 0; rd_if.rd_ready = 0;
    m_prev = 0; m_moves = 0; m_stall = 0; m_mode = 0; m_ovf = 0; m_arr = 0;
    #2;
    // Reset state.
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    // Start entry and in-order readout of 2,3,5,1.
    cyc(0, 1, 2, 7, 0);
    cyc(0, 1, 3, 7, 1);
    cyc(0, 1, 5, 7, 1);
    cyc(0, 1, 1, 7, 1);
    cyc(0, 1, 1, 7, 1);
    cyc(0, 0, 1, 7, 1);
    // Arrival on 5; 6 not logged; stays arrived until log_enable drops.
    cyc(1, 0, 0, 5, 0);
    cyc(0, 1, 0, 5, 0);
    cyc(0, 1, 4, 5, 0);
    cyc(0, 1, 5, 5, 0);
    cyc(0, 1, 6, 5, 0);
    cyc(0, 1, 2, 5, 1);
    cyc(0, 0, 2, 5, 1);
    cyc(0, 0, 2, 5, 1);
    // Overflow: 9 distinct pushes, then push plus pop while full.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 1, (i % 7) + 1, 0, 0);
    cyc(0, 1, 3, 0, 1);
    // Stall: hold location 16 cycles, then move.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 3, 0, 1);
    for (int i = 0; i < STALL + 2; i++) cyc(0, 1, 3, 0, 1);
    cyc(0, 1, 4, 0, 1);
    // Mid-stream reset with 5 entries and 4 moves; narrow counter saturates.
    cyc(1, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) cyc(0, 1, i, 0, 0);
    cyc(1, 1, 6, 0, 1);
    cyc(0, 0, 6, 0, 0);
    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) != 0),
          $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 1));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
